fifo_sync_lsram: RTL
====================

FIFO_SYNC_LSRAM -- requirements
Module: fifo_sync_lsram

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH_LOG2, default 7, log2 of entry count (DEPTH = 2^DEPTH_LOG2, range 2..12).
REQ-003 SHALL have parameter AFULL_TH, default 120, AFULL asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 8, AEMPTY asserts when count <= AEMPTY_TH.
REQ-005 SHALL have one clock and an active-high asynchronous reset.
REQ-006 SHALL have ports:
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous active-high reset.
- WDATA  in  WIDTH  write data.
- WE  in  1  write request.
- RE  in  1  read request.
- RDATA  out  WIDTH  read data.
- RVALID  out  1  RDATA carries a newly read word this cycle.
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- OVERFLOW  out  1  one-cycle pulse: rejected write.
- UNDERFLOW  out  1  one-cycle pulse: rejected read.
- WRCNT  out  DEPTH_LOG2+1  current occupancy.

Function
REQ-007 SHALL store data in an inferred single-clock simple-dual-port RAM: one write port, one read port, DEPTH x WIDTH.
REQ-008 SHALL accept a write when WE=1 and FULL=0, storing WDATA at the write pointer and incrementing it.
REQ-009 SHALL accept a read when RE=1 and EMPTY=0, reading at the read pointer and incrementing it.
REQ-010 SHALL reject WE when FULL=1, even if a read is accepted in the same cycle, and pulse OVERFLOW the next cycle with no state change.
REQ-011 SHALL reject RE when EMPTY=1, even if a write is accepted in the same cycle, and pulse UNDERFLOW the next cycle.
REQ-012 SHALL use DEPTH_LOG2+1 bit pointers that wrap modulo 2*DEPTH; address = low DEPTH_LOG2 bits; full/empty derived from the MSB and address comparison.
REQ-013 SHALL update WRCNT as +1 on write only, -1 on read only, and leave it unchanged on a simultaneous accepted read and write.
REQ-014 SHALL register all flags so they reflect WRCNT after the current cycle's accepted operations, valid on the following cycle.
REQ-015 SHALL present RDATA and RVALID=1 one cycle after an accepted read (base latency); RVALID=0 in all other cycles.
REQ-016 SHALL hold RDATA at its last value when no read completes.
REQ-017 SHALL preserve data order across pointer wrap-around.

Reset
REQ-018 SHALL on RESET=1 asynchronously clear pointers, WRCNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0, RVALID=0, RDATA=0.
REQ-019 SHALL discard any in-flight read on reset mid-operation, so no RVALID pulse appears after release; RAM contents are not cleared.
REQ-020 SHALL ignore WE/RE on the first rising edge that coincides with RESET=1.

Configuration
REQ-021 SHALL, when macro FIFO_SYNC_LSRAM_RDPIPE_EN is defined, add an output register stage: RDATA/RVALID appear two cycles after an accepted read, and the pipeline register is reset per REQ-018/019.
REQ-022 SHALL, when FIFO_SYNC_LSRAM_RDPIPE_EN is undefined, use the one-cycle latency of REQ-015 with no extra register.

Verification
REQ-023 Reset, then write 0x11,0x22,0x33, then read 3 -> RDATA 0x11,0x22,0x33 with RVALID at latency 1 (2 with macro), then EMPTY=1.
REQ-024 Write 128 words (defaults) -> FULL=1, WRCNT=128, AFULL=1 from count 120; a 129th WE -> OVERFLOW pulse, WRCNT stays 128.
REQ-025 RE while empty -> UNDERFLOW one-cycle pulse, RVALID=0, WRCNT=0.
REQ-026 At count 64, WE=RE=1 for 10 cycles -> WRCNT stays 64, read data matches write order; at FULL, WE=RE=1 -> read accepted, write rejected, OVERFLOW=1.
REQ-027 Stream 300 words with random gaps -> output sequence equals input across pointer wrap-around.
REQ-028 Assert RESET for one cycle one cycle after an accepted read -> no RVALID, EMPTY=1, WRCNT=0 after release.

Source files
------------

// File: rtl/fifo_sync_lsram.sv
// fifo_sync_lsram: single-clock FIFO on an inferred simple-dual-port RAM.
// Defining FIFO_SYNC_LSRAM_RDPIPE_EN adds an output register (read latency 2).
// Ports: CLOCK, RESET (async, active high); WDATA/WE write side;
//   RE/RDATA/RVALID read side; FULL/EMPTY/AFULL/AEMPTY registered flags;
//   OVERFLOW/UNDERFLOW one-cycle reject pulses; WRCNT occupancy.
module fifo_sync_lsram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter int AFULL_TH   = 120,
  parameter int AEMPTY_TH  = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      WDATA,
  input  logic                  WE,
  input  logic                  RE,
  output logic [WIDTH-1:0]      RDATA,
  output logic                  RVALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [DEPTH_LOG2:0]   WRCNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ram_q, ram_d;
  logic             ram_vld_q, ram_vld_d;
  logic             we_ok;
  logic             re_ok;

  always_comb begin
    we_ok    = WE && !full_q;
    re_ok    = RE && !empty_q;
    wr_ptr_d = we_ok ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = re_ok ? rd_ptr_q + ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    if (we_ok && !re_ok) begin
      cnt_d = cnt_q + ONE;
    end else if (re_ok && !we_ok) begin
      cnt_d = cnt_q - ONE;
    end
    // Equal addresses: MSBs equal means empty, MSBs differ means full.
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    afull_d   = int'(cnt_d) >= AFULL_TH;
    aempty_d  = int'(cnt_d) <= AEMPTY_TH;
    ovf_d     = WE && full_q;
    unf_d     = RE && empty_q;
    ram_vld_d = re_ok;
    ram_d     = re_ok ? mem[rd_ptr_q[AW-1:0]] : ram_q;
  end

  // RAM array carries no reset; writes are blocked while RESET is high.
  always_ff @(posedge CLOCK) begin
    if (we_ok && !RESET) begin
      mem[wr_ptr_q[AW-1:0]] <= WDATA;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ram_q     <= '0;
      ram_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ram_q     <= ram_d;
      ram_vld_q <= ram_vld_d;
    end
  end

`ifdef FIFO_SYNC_LSRAM_RDPIPE_EN
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;

  always_comb begin
    out_vld_d = ram_vld_q;
    out_d     = ram_vld_q ? ram_q : out_q;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign RDATA  = out_q;
  assign RVALID = out_vld_q;
`else
  assign RDATA  = ram_q;
  assign RVALID = ram_vld_q;
`endif

  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
  assign WRCNT     = cnt_q;

endmodule
